// File: rtl/trace_lockstep_if.sv
// Lockstep trace bus: data-side request streams from the DUT and reference cores plus checker status.
// The checker uses the slave modport. The stimulus side, the bench or the surrounding SoC, uses the master modport.
interface trace_lockstep_if;
  logic        enable_i;
  logic [31:0] dut_addr_i,    ref_addr_i;
  logic [31:0] dut_data_wr_i, ref_data_wr_i;
  logic [3:0]  dut_wr_i,      ref_wr_i;
  logic        dut_rd_i,      ref_rd_i;
  logic        dut_accept_i,  ref_accept_i;
  logic        mismatch_o;
  logic        overflow_o;
  logic [31:0] fail_addr_o;
  logic [31:0] match_count_o;
  logic        busy_o;

  modport master (
    output enable_i, dut_addr_i, ref_addr_i, dut_data_wr_i, ref_data_wr_i,
           dut_wr_i, ref_wr_i, dut_rd_i, ref_rd_i, dut_accept_i, ref_accept_i,
    input  mismatch_o, overflow_o, fail_addr_o, match_count_o, busy_o
  );

  modport slave (
    input  enable_i, dut_addr_i, ref_addr_i, dut_data_wr_i, ref_data_wr_i,
           dut_wr_i, ref_wr_i, dut_rd_i, ref_rd_i, dut_accept_i, ref_accept_i,
    output mismatch_o, overflow_o, fail_addr_o, match_count_o, busy_o
  );
endinterface

// File: rtl/trace_lockstep_checker.sv
// Captures accepted DUT/reference data requests into per-side FIFOs and compares the heads pairwise, latching the first divergence.
// Read capture exists only when TRACE_CMP_READS_EN is defined. Otherwise only writes are compared.
module trace_lockstep_checker #(
  parameter int DEPTH = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  trace_lockstep_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t FULL_XOR = ptr_t'(1) << AW;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        is_read;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, FAILED = 2'd2} state_t;

  state_t      state_q, state_d;
  ptr_t        dut_wp_q, dut_wp_d, dut_rp_q, dut_rp_d;
  ptr_t        ref_wp_q, ref_wp_d, ref_rp_q, ref_rp_d;
  logic        mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic [31:0] fail_addr_q, fail_addr_d, match_count_q, match_count_d;
  entry_t      dut_mem_q [DEPTH];
  entry_t      ref_mem_q [DEPTH];

  entry_t      dut_entry, ref_entry, dut_head, ref_head;
  logic        dut_req, ref_req, dut_empty, ref_empty, dut_full, ref_full;
  logic        in_check, pop, pair_match, dut_push, ref_push, dut_ovf, ref_ovf, fail_now;
  logic [31:0] byte_mask;

  always_comb begin
    dut_entry = '{addr: bus.dut_addr_i, data: bus.dut_data_wr_i, strb: bus.dut_wr_i, is_read: 1'b0};
    ref_entry = '{addr: bus.ref_addr_i, data: bus.ref_data_wr_i, strb: bus.ref_wr_i, is_read: 1'b0};
    dut_req   = bus.dut_accept_i && (bus.dut_wr_i != 4'h0);
    ref_req   = bus.ref_accept_i && (bus.ref_wr_i != 4'h0);
`ifdef TRACE_CMP_READS_EN
    // A read is recorded only when no strobe is set, so writes win when both are asserted.
    dut_entry.is_read = (bus.dut_wr_i == 4'h0);
    ref_entry.is_read = (bus.ref_wr_i == 4'h0);
    dut_req = bus.dut_accept_i && ((bus.dut_wr_i != 4'h0) || bus.dut_rd_i);
    ref_req = bus.ref_accept_i && ((bus.ref_wr_i != 4'h0) || bus.ref_rd_i);
`endif
  end

`ifndef TRACE_CMP_READS_EN
  logic unused_rd;
  assign unused_rd = bus.dut_rd_i ^ bus.ref_rd_i;
`endif

  assign dut_empty = (dut_wp_q == dut_rp_q);
  assign ref_empty = (ref_wp_q == ref_rp_q);
  assign dut_full  = ((dut_wp_q ^ dut_rp_q) == FULL_XOR);
  assign ref_full  = ((ref_wp_q ^ ref_rp_q) == FULL_XOR);
  assign dut_head  = dut_mem_q[dut_rp_q[AW-1:0]];
  assign ref_head  = ref_mem_q[ref_rp_q[AW-1:0]];

  assign byte_mask  = {{8{dut_head.strb[3]}}, {8{dut_head.strb[2]}},
                       {8{dut_head.strb[1]}}, {8{dut_head.strb[0]}}};
  assign pair_match = (dut_head.addr == ref_head.addr) && (dut_head.strb == ref_head.strb) &&
                      (dut_head.is_read == ref_head.is_read) &&
                      (dut_head.is_read || (((dut_head.data ^ ref_head.data) & byte_mask) == 32'h0));

  assign in_check = (state_q == CHECK);
  assign pop      = in_check && !dut_empty && !ref_empty;
  // A full FIFO still takes a push when the same edge frees its head.
  assign dut_push = in_check && dut_req && (!dut_full || pop);
  assign ref_push = in_check && ref_req && (!ref_full || pop);
  assign dut_ovf  = in_check && dut_req && dut_full && !pop;
  assign ref_ovf  = in_check && ref_req && ref_full && !pop;
  assign fail_now = (pop && !pair_match) || dut_ovf || ref_ovf;

  always_comb begin
    state_d       = state_q;
    dut_wp_d      = dut_wp_q;
    dut_rp_d      = dut_rp_q;
    ref_wp_d      = ref_wp_q;
    ref_rp_d      = ref_rp_q;
    mismatch_d    = mismatch_q;
    overflow_d    = overflow_q;
    fail_addr_d   = fail_addr_q;
    match_count_d = match_count_q;
    case (state_q)
      IDLE: if (bus.enable_i) state_d = CHECK;
      CHECK: begin
        if (pop) begin
          dut_rp_d = dut_rp_q + ptr_t'(1);
          ref_rp_d = ref_rp_q + ptr_t'(1);
          if (pair_match) begin
            if (match_count_q != 32'hFFFF_FFFF) match_count_d = match_count_q + 32'd1;
          end else begin
            mismatch_d  = 1'b1;
            fail_addr_d = dut_head.addr;
          end
        end
        if (dut_push) dut_wp_d = dut_wp_q + ptr_t'(1);
        if (ref_push) ref_wp_d = ref_wp_q + ptr_t'(1);
        if (dut_ovf || ref_ovf) overflow_d = 1'b1;
        // A failure outranks a simultaneous disable, so the evidence is not flushed away.
        if (fail_now) begin
          state_d = FAILED;
        end else if (!bus.enable_i) begin
          state_d  = IDLE;
          dut_wp_d = '0;
          dut_rp_d = '0;
          ref_wp_d = '0;
          ref_rp_d = '0;
        end
      end
      default: state_d = FAILED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      dut_wp_q      <= '0;
      dut_rp_q      <= '0;
      ref_wp_q      <= '0;
      ref_rp_q      <= '0;
      mismatch_q    <= 1'b0;
      overflow_q    <= 1'b0;
      fail_addr_q   <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dut_wp_q      <= dut_wp_d;
      dut_rp_q      <= dut_rp_d;
      ref_wp_q      <= ref_wp_d;
      ref_rp_q      <= ref_rp_d;
      mismatch_q    <= mismatch_d;
      overflow_q    <= overflow_d;
      fail_addr_q   <= fail_addr_d;
      match_count_q <= match_count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (dut_push) dut_mem_q[dut_wp_q[AW-1:0]] <= dut_entry;
    if (ref_push) ref_mem_q[ref_wp_q[AW-1:0]] <= ref_entry;
  end

  assign bus.mismatch_o    = mismatch_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.fail_addr_o   = fail_addr_q;
  assign bus.match_count_o = match_count_q;
  assign bus.busy_o        = !dut_empty || !ref_empty;
endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Bench for trace_lockstep_checker: directed scenarios with literal expectations, then randomized traffic.
// A queue-based model of the capture and compare rules is checked against the DUT on every falling edge.
module tb_trace_lockstep_checker;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  trace_lockstep_if bus();

  trace_lockstep_checker #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        rd;
  } ent_t;

  // Model state: 0 = idle, 1 = checking, 2 = failed.
  int          m_state;
  ent_t        mq_d[$];
  ent_t        mq_r[$];
  bit          m_mism, m_ovf;
  logic [31:0] m_faddr, m_cnt;

  function automatic void model_reset();
    m_state = 0;
    mq_d.delete();
    mq_r.delete();
    m_mism  = 0;
    m_ovf   = 0;
    m_faddr = 0;
    m_cnt   = 0;
  endfunction

  function automatic bit wants(input logic acc, input logic [3:0] wr, input logic rd);
    bit w;
    w = acc && (wr != 4'h0);
`ifdef TRACE_CMP_READS_EN
    w = w || (acc && rd);
`else
    if (rd) w = w;
`endif
    return w;
  endfunction

  function automatic bit pair_ok(input ent_t x, input ent_t y);
    if (x.addr != y.addr || x.strb != y.strb || x.rd != y.rd) return 0;
    if (x.rd) return 1;
    for (int b = 0; b < 4; b++)
      if (x.strb[b] && (x.data[8*b +: 8] != y.data[8*b +: 8])) return 0;
    return 1;
  endfunction

  function automatic void model_step();
    ent_t ed, er, hd, hr;
    bit pd, pr, fail;
    pd = wants(bus.dut_accept_i, bus.dut_wr_i, bus.dut_rd_i);
    pr = wants(bus.ref_accept_i, bus.ref_wr_i, bus.ref_rd_i);
    ed.addr = bus.dut_addr_i; ed.data = bus.dut_data_wr_i; ed.strb = bus.dut_wr_i; ed.rd = (bus.dut_wr_i == 4'h0);
    er.addr = bus.ref_addr_i; er.data = bus.ref_data_wr_i; er.strb = bus.ref_wr_i; er.rd = (bus.ref_wr_i == 4'h0);
    if (m_state == 0) begin
      if (bus.enable_i) m_state = 1;
    end else if (m_state == 1) begin
      fail = 0;
      if (mq_d.size() > 0 && mq_r.size() > 0) begin
        hd = mq_d.pop_front();
        hr = mq_r.pop_front();
        if (pair_ok(hd, hr)) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
          m_mism = 1; m_faddr = hd.addr; fail = 1;
        end
      end
      if (pd) begin
        if (mq_d.size() < DEPTH) mq_d.push_back(ed);
        else begin m_ovf = 1; fail = 1; end
      end
      if (pr) begin
        if (mq_r.size() < DEPTH) mq_r.push_back(er);
        else begin m_ovf = 1; fail = 1; end
      end
      if (fail) m_state = 2;
      else if (!bus.enable_i) begin
        mq_d.delete(); mq_r.delete(); m_state = 0;
      end
    end
  endfunction

  always @(posedge clk) if (rst_n) model_step();

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model mismatch_o",    {31'b0, bus.mismatch_o}, {31'b0, m_mism});
      check("model overflow_o",    {31'b0, bus.overflow_o}, {31'b0, m_ovf});
      check("model fail_addr_o",   bus.fail_addr_o, m_faddr);
      check("model match_count_o", bus.match_count_o, m_cnt);
      check("model busy_o",        {31'b0, bus.busy_o}, {31'b0, (mq_d.size() > 0 || mq_r.size() > 0)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.dut_accept_i = 0; bus.dut_wr_i = 0; bus.dut_rd_i = 0; bus.dut_addr_i = 0; bus.dut_data_wr_i = 0;
    bus.ref_accept_i = 0; bus.ref_wr_i = 0; bus.ref_rd_i = 0; bus.ref_addr_i = 0; bus.ref_data_wr_i = 0;
  endtask

  task automatic set_dut(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.dut_accept_i = 1; bus.dut_addr_i = a; bus.dut_data_wr_i = d; bus.dut_wr_i = s; bus.dut_rd_i = 0;
  endtask

  task automatic set_ref(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ref_accept_i = 1; bus.ref_addr_i = a; bus.ref_data_wr_i = d; bus.ref_wr_i = s; bus.ref_rd_i = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mismatch_o"},    {31'b0, bus.mismatch_o}, 32'd0);
    check({tag, " overflow_o"},    {31'b0, bus.overflow_o}, 32'd0);
    check({tag, " fail_addr_o"},   bus.fail_addr_o, 32'd0);
    check({tag, " match_count_o"}, bus.match_count_o, 32'd0);
    check({tag, " busy_o"},        {31'b0, bus.busy_o}, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.enable_i = 0;
    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
  endtask

  task automatic start();
    bus.enable_i = 1;
    tick();
  endtask

  ent_t exp_q[$];
  ent_t e;
  int   stall;
  logic [31:0] mask, rdat;

  initial begin
    model_reset();
    bus.enable_i = 0;
    idle_inputs();
    #12;
    check_all_zero("reset");
    @(posedge clk); #2;
    rst_n = 1;
    cmp_on = 1;

    // Identical full-word writes match.
    do_reset(); start();
    set_dut(32'h100, 32'hDEADBEEF, 4'hF); set_ref(32'h100, 32'hDEADBEEF, 4'hF);
    tick(); idle_inputs();
    check("match busy after push", {31'b0, bus.busy_o}, 32'd1);
    tick();
    check("match count", bus.match_count_o, 32'd1);
    check("match no mismatch", {31'b0, bus.mismatch_o}, 32'd0);

    // Bytes outside the strobe are ignored.
    do_reset(); start();
    set_dut(32'h104, 32'h000000AA, 4'h1); set_ref(32'h104, 32'hFF0000AA, 4'h1);
    tick(); idle_inputs(); tick();
    check("masked count", bus.match_count_o, 32'd1);
    check("masked no mismatch", {31'b0, bus.mismatch_o}, 32'd0);

    // A data divergence is latched, and later matches are ignored.
    do_reset(); start();
    set_dut(32'h200, 32'h1, 4'hF); set_ref(32'h200, 32'h2, 4'hF);
    tick(); idle_inputs(); tick();
    check("diverge mismatch", {31'b0, bus.mismatch_o}, 32'd1);
    check("diverge fail_addr", bus.fail_addr_o, 32'h200);
    set_dut(32'h300, 32'h5, 4'hF); set_ref(32'h300, 32'h5, 4'hF);
    tick(); idle_inputs(); tick(); tick();
    check("failed count frozen", bus.match_count_o, 32'd0);
    bus.enable_i = 0;
    tick(); tick();
    check("failed sticky", {31'b0, bus.mismatch_o}, 32'd1);
    check("failed addr kept", bus.fail_addr_o, 32'h200);

    // Nine writes on one side overflow an eight-entry FIFO.
    do_reset(); start();
    for (int i = 0; i < 9; i++) begin
      set_dut(32'h400 + 32'(i) * 4, 32'(i), 4'hF);
      tick();
      if (i == 7) check("overflow after 8", {31'b0, bus.overflow_o}, 32'd0);
    end
    idle_inputs();
    check("overflow after 9", {31'b0, bus.overflow_o}, 32'd1);

    // The reference lags by five cycles over a twenty-write stream.
    do_reset(); start();
    for (int c = 0; c < 25; c++) begin
      idle_inputs();
      if (c < 20) set_dut(32'h1000 + 32'(c) * 4, 32'hA5000000 + 32'(c), 4'hF);
      if (c >= 5) set_ref(32'h1000 + 32'(c - 5) * 4, 32'hA5000000 + 32'(c - 5), 4'hF);
      tick();
    end
    idle_inputs(); tick(); tick();
    check("skew count", bus.match_count_o, 32'd20);
    check("skew busy", {31'b0, bus.busy_o}, 32'd0);
    check("skew no mismatch", {31'b0, bus.mismatch_o}, 32'd0);

    // Reset mid-stream clears everything asynchronously.
    do_reset(); start();
    for (int i = 0; i < 3; i++) begin
      set_dut(32'h500 + 32'(i) * 4, 32'(i), 4'hF);
      tick();
    end
    idle_inputs();
    check("midreset busy before", {31'b0, bus.busy_o}, 32'd1);
    rst_n = 0;
    model_reset();
    #1;
    check_all_zero("midreset");
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_dut(32'h600 + 32'(i) * 4, 32'h11 * 32'(i), 4'h3);
      set_ref(32'h600 + 32'(i) * 4, 32'h11 * 32'(i), 4'h3);
      tick();
    end
    idle_inputs(); tick();
    check("midreset recount", bus.match_count_o, 32'd4);

    // Randomized traffic against the model.
    do_reset(); start();
    exp_q.delete();
    stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (m_state == 2 || $urandom_range(0, 999) == 0) begin
        do_reset(); start(); exp_q.delete();
      end
      idle_inputs();
      bus.enable_i = ($urandom_range(0, 299) != 0);
      if (!bus.enable_i) exp_q.delete();
      if (cyc % 600 == 0) stall = 12;
      case ($urandom_range(0, 5))
        0, 1: begin
          e.addr = 32'($urandom_range(0, 15)) << 2;
          e.data = $urandom;
          e.strb = 4'($urandom_range(1, 15));
          e.rd = 0;
          set_dut(e.addr, e.data, e.strb);
          if ($urandom_range(0, 9) == 0) bus.dut_accept_i = 0;
          else exp_q.push_back(e);
        end
        2: begin bus.dut_accept_i = 1; bus.dut_rd_i = 1; bus.dut_addr_i = $urandom; end
        default: ;
      endcase
      if (stall > 0) stall--;
      else if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        e = exp_q.pop_front();
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{e.strb[b]}};
        rdat = (e.data & mask) | ($urandom & ~mask);
        if ($urandom_range(0, 59) == 0) begin
          if (e.strb[0]) rdat = rdat ^ 32'h1;
          else e.addr = e.addr ^ 32'h4;
        end
        set_ref(e.addr, rdat, e.strb);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.ref_accept_i = 1; bus.ref_rd_i = 1; bus.ref_addr_i = $urandom;
      end
      tick();
    end
    idle_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
